// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Iterative binary to packed-BCD converter that uses shift-and-add-3
// (double dabble) and does one shift per clock. It sits between the
// calculator's binary arithmetic result and the 7-segment digit drivers.
//
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - synchronous reset, active low
//   start    - request a conversion of bin; sampled only while idle
//   bin      - unsigned binary operand (W bits), captured when start is accepted
//   bcd      - packed BCD result (D digits); digit k is bcd[4k+3:4k], digit 0 = ones
//   busy     - high while a conversion is in progress (exactly W cycles)
//   done     - one-cycle pulse when bcd has just been updated
//
// Timing: start is accepted at edge 0, shifts happen at edges 1..W, and
// done/bcd are valid in the cycle after edge W. bcd keeps the previous
// result until a conversion completes, and is cleared only by reset.
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
   parameter int unsigned W = 16,
   parameter int unsigned D = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [W-1:0]     bin,
   output logic [4*D-1:0]   bcd,
   output logic             busy,
   output logic             done
);

   localparam int unsigned BW = 4 * D;
   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   // True when D decimal digits can hold the largest W-bit value (10^D > 2^W - 1).
   // The power of ten saturates so that very large D cannot overflow the check.
   function automatic bit digits_fit(input int unsigned w, input int unsigned d);
      longint unsigned pow10;
      longint unsigned maxv;
      bit              sat;
      pow10 = 64'd1;
      sat   = 1'b0;
      for (int unsigned i = 0; i < d; i++) begin
         if (pow10 > 64'd1844674407370955161) sat = 1'b1;
         else                                  pow10 = pow10 * 64'd10;
      end
      maxv = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      return sat || (pow10 > maxv);
   endfunction

   // Reject parameter sets that cannot represent every input value.
   if (W == 0 || !digits_fit(W, D)) begin : g_param_check
      $error("bin_to_bcd_seq: need W >= 1 and 10**D > 2**W - 1 (W=%0d, D=%0d)", W, D);
   end

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t          state;
   logic [BW-1:0]   work_bcd;
   logic [W-1:0]    work_bin;
   logic [CW-1:0]   cnt;

   logic [BW-1:0]   adj_bcd;
   logic [BW-1:0]   shl_bcd;
   logic [W-1:0]    shl_bin;

   // Add 3 to every digit >= 5 so that the following shift carries into the next digit.
   always_comb begin
      adj_bcd = work_bcd;
      for (int unsigned k = 0; k < D; k++) begin
         if (work_bcd[4*k +: 4] >= 4'd5) begin
            adj_bcd[4*k +: 4] = work_bcd[4*k +: 4] + 4'd3;
         end
      end
   end

   // One left shift of {bcd, bin}: the binary MSB enters the ones-digit LSB.
   always_comb begin
      shl_bcd = {adj_bcd[BW-2:0], work_bin[W-1]};
      shl_bin = work_bin << 1;
   end

   // Control FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         work_bcd <= '0;
         work_bin <= '0;
         cnt      <= '0;
         bcd      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  work_bin <= bin;
                  work_bcd <= '0;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               work_bcd <= shl_bcd;
               work_bin <= shl_bin;
               cnt      <= cnt + CW'(1);
               // The W-th shift completes the conversion and publishes the result.
               if (cnt == LAST) begin
                  bcd   <= shl_bcd;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
